// File: rtl/mux_rr_reg_if.sv
// Handshake bundle for mux_rr_reg: NCH producer channels in, one registered word out.
// master = producers/consumer side, slave = the arbiter itself.
interface mux_rr_reg_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NCH   = 4
);
  localparam int unsigned SELW = $clog2(NCH);

  logic                 prio_mode;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_sel;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output prio_mode, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  prio_mode, in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/mux_rr_reg.sv
// Arbitrated N:1 registered mux with valid/ready on every channel and on the output.
// Round-robin or fixed-priority grant; full throughput via drain-and-reload in one cycle.
module mux_rr_reg #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NCH   = 4
) (
  input logic         clk,
  input logic         rst,
  mux_rr_reg_if.slave bus
);
  localparam int unsigned SELW = $clog2(NCH);

  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  gidx;
  logic [SELW-1:0]  sel_q;
  logic             found;
  logic             load_en;
  logic             valid_q;
  logic [WIDTH-1:0] gdata;
  logic [WIDTH-1:0] data_q;

  assign load_en = !valid_q || bus.out_ready;

  // First requester at or after the search start; start is 0 in fixed-priority mode.
  always_comb begin
    int unsigned     cand;
    logic [SELW-1:0] c;
    found = 1'b0;
    gidx  = '0;
    cand  = 0;
    c     = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      cand = bus.prio_mode ? k : (32'(rr_ptr) + k) % NCH;
      c    = SELW'(cand);
      if (!found && bus.in_valid[c]) begin
        found = 1'b1;
        gidx  = c;
      end
    end
  end

  always_comb begin
    gdata = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (gidx == SELW'(i)) gdata = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    bus.in_ready = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      bus.in_ready[i] = !rst && load_en && found && (gidx == SELW'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      rr_ptr  <= '0;
    end else if (load_en) begin
      if (found) begin
        valid_q <= 1'b1;
        data_q  <= gdata;
        sel_q   <= gidx;
        rr_ptr  <= (gidx == SELW'(NCH-1)) ? '0 : gidx + SELW'(1);
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
endmodule
